mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous up/down counter; generalises the team's 4-bit ripple toggle counter to arbitrary width and modulus, with direction control, parallel load, synchronous clear, optional saturation and a cascadable terminal-count output. All state bits change on the same clock edge, so there is no ripple skew. Used as a general event/divider counter and chained through `tc`/`en` for wider counts.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits, 1 to 32.
- `MODULUS`, 16: count range 0 .. MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- `SATURATE`, 0: 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en`  in  1  count enable; one step per cycle while high.
- `up_dn`  in  1  1 = count up, 0 = count down.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  value for `load`.
- `q`  out  WIDTH  registered count.
- `tc`  out  1  combinational terminal count, for cascading.
- `wrap`  out  1  registered one-cycle pulse after a wrap or saturation hit.
- `load_err`  out  1  registered one-cycle pulse after an out-of-range load.

## Operation
- Per-edge priority: `clr` > `load` > `en` > hold.
- `clr`: q ← 0; no `wrap`, no `load_err`.
- `load`: if load_val < MODULUS then q ← load_val; otherwise q ← MODULUS-1 and `load_err` pulses. `en` is ignored that cycle.
- `en` with up_dn=1: if q < MODULUS-1 then q ← q+1. At q = MODULUS-1: SATURATE=0 gives q ← 0; SATURATE=1 holds q.
- `en` with up_dn=0: if q > 0 then q ← q-1. At q = 0: SATURATE=0 gives q ← MODULUS-1; SATURATE=1 holds q.
- `wrap` asserts on the edge after any enabled step taken from the terminal value (MODULUS-1 going up, 0 going down), in both modes. In SATURATE=1 a held counter with `en` high pulses `wrap` every cycle.
- `tc` = en & (up_dn ? q==MODULUS-1 : q==0). Cascade by driving a higher stage's `en` from a lower stage's `tc`, with `up_dn` shared.
- Arithmetic is done in WIDTH+1 bits internally, so MODULUS = 2^WIDTH needs no overflow special case.
- A direction change takes effect on the next enabled edge. There is no turnaround penalty.

## Timing
- Reset (reset=0, asynchronous): q=0, wrap=0, load_err=0 immediately, independent of `clk`. `tc` follows the equation above, so it equals en & ~up_dn during reset.
- Release of reset is synchronised by the user. First count edge is the first rising edge with reset=1.
- Latency: `q` updates 1 cycle after qualifying inputs. `wrap` and `load_err` are high exactly the cycle in which the new `q` is visible.
- `tc` has zero latency, combinational from `q`, `en` and `up_dn`. It has no path from `load`, `clr` or `load_val`.
- Reset asserted mid-count aborts all pending pulses. There is no state retention.

## Structure
- Shared package `counter_pkg`: mode encoding constants `CNT_WRAP`/`CNT_SAT`, direction constants `DIR_UP`/`DIR_DN`, and function `clog2`, for reuse by future divider blocks.
- One sub-module, `count_next`: combinational next-value and wrap-flag logic from q, up_dn and the parameters. The top holds the registers, priority mux, load check and `tc`.
- Parameter legality is checked at elaboration. An illegal MODULUS or WIDTH is a fatal elaboration error.

## Test plan
- WIDTH=4, MODULUS=10, SATURATE=0, en=1, up_dn=1 from reset for 12 cycles → q goes 0..9, 0, 1. tc is high only while q=9. wrap is high in the cycle q=0 after 9.
- Same configuration, up_dn=0 from reset → q goes 9, 8, …. tc is high at q=0 before the step. wrap pulses with q=9.
- SATURATE=1, MODULUS=10, count up to 9 with en held high 3 more cycles → q stays 9 and wrap pulses on each of those 3 cycles. Then up_dn=0 → q=8.
- load=1 with load_val=7 and en=1 → q=7, load_err=0. load_val=12 → q=9, load_err pulses 1 cycle. clr=1 together with load=1 and load_val=3 → q=0.
- reset taken low between clock edges at q=5 → q=0 immediately. After release with en=1, q=1 on the first rising edge.
- Two WIDTH=4, MODULUS=10 instances cascaded, with the upper en driven by the lower tc, counting up 100 cycles from reset → {upper, lower} goes 00..99 then 00. Random interleaving of clr/load/en/up_dn is checked against a reference model.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the counter/divider family.
//   CNT_WRAP / CNT_SAT : values for a counter's SATURATE parameter.
//   DIR_UP / DIR_DN    : encoding of the up_dn input.
//   clog2()            : bits needed to hold values 0 .. value-1.
package counter_pkg;

   localparam int   CNT_WRAP = 0;
   localparam int   CNT_SAT  = 1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DN   = 1'b0;

   // Bits needed to represent 0 .. value-1 (returns 0 for value <= 1).
   function automatic int clog2(input longint unsigned value);
      logic [63:0] v;
      int          bits;
      v    = (value > 64'd0) ? value - 64'd1 : 64'd0;
      bits = 0;
      for (int i = 0; i < 64; i++) begin
         if (v[i]) bits = i + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/count_next.sv
// count_next
//   Combinational next-count and terminal-step logic for a modulo counter.
//   Ports:
//     q       in  WIDTH  current count (always within 0 .. MODULUS-1)
//     up_dn   in  1      DIR_UP / DIR_DN
//     q_next  out WIDTH  count after one enabled step
//     wrap    out 1      the step left the range (wrapped or was held)
module count_next
   import counter_pkg::*;
#(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int              SATURATE = CNT_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up_dn,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap
);

   // One extra bit so MODULUS = 2^WIDTH needs no overflow special case:
   // a step past the top shows as a value above TOP, a step below zero
   // shows as the borrow in the extra bit.
   localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] cand;
   logic           out_of_range;

   // NOTE: every output of a combinational block gets a value before any
   // branch, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      q_ext        = {1'b0, q};
      cand         = q_ext;
      out_of_range = 1'b0;
      q_next       = q;
      wrap         = 1'b0;

      if (up_dn == DIR_UP) begin
         cand         = q_ext + ONE;
         out_of_range = (cand > TOP);
      end else begin
         cand         = q_ext - ONE;
         out_of_range = cand[WIDTH];
      end

      if (out_of_range) begin
         wrap = 1'b1;
         if (SATURATE == CNT_SAT) begin
            q_next = q;
         end else if (up_dn == DIR_UP) begin
            q_next = '0;
         end else begin
            q_next = TOP[WIDTH-1:0];
         end
      end else begin
         q_next = cand[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Synchronous modulo up/down counter with parallel load, synchronous
//   clear, optional saturation and a cascadable terminal count.
//   Ports:
//     clk       in  1      rising-edge clock
//     reset     in  1      asynchronous, active-low reset
//     en        in  1      count enable (one step per cycle)
//     up_dn     in  1      1 = up, 0 = down
//     clr       in  1      synchronous clear (highest priority)
//     load      in  1      synchronous parallel load
//     load_val  in  WIDTH  value for load; out-of-range loads MODULUS-1
//     q         out WIDTH  registered count
//     tc        out 1      combinational terminal count (drives next stage's en)
//     wrap      out 1      registered pulse after a step from a terminal value
//     load_err  out 1      registered pulse after an out-of-range load
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int              SATURATE = CNT_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "mod_updown_counter: WIDTH must be 1..32");
   end
   if (MODULUS < 64'd2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $fatal(1, "mod_updown_counter: MODULUS must be 2..2^WIDTH");
   end
   if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
      $fatal(1, "mod_updown_counter: SATURATE must be 0 or 1");
   end

   localparam logic [WIDTH:0] TOP     = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] q_step;
   logic             step_wrap;
   logic             load_ok;

   count_next #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .q      (q),
      .up_dn  (up_dn),
      .q_next (q_step),
      .wrap   (step_wrap)
   );

   assign load_ok = ({1'b0, load_val} < MOD_EXT);

   // Zero-latency cascade output: no path from clr/load/load_val.
   assign tc = en & ((up_dn == DIR_UP) ? ({1'b0, q} == TOP) : (q == '0));

   // NOTE: registers are written with non-blocking assignments so every
   // flop samples the pre-edge values and the whole count moves together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         // Pulses default low; only the branch taken this edge raises one.
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (clr) begin
            q <= '0;
         end else if (load) begin
            if (load_ok) begin
               q <= load_val;
            end else begin
               q        <= TOP[WIDTH-1:0];
               load_err <= 1'b1;
            end
         end else if (en) begin
            q    <= q_step;
            wrap <= step_wrap;
         end
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter
//   Drives a wrapping and a saturating MODULUS=10 counter and a full-range
//   WIDTH=3 counter from shared inputs, plus a two-digit decimal cascade,
//   and compares all of them against an integer reference model.
module tb_mod_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_en, a_up, a_clr, a_load;
   logic [3:0] a_lv;

   logic [3:0] w_q, s_q;
   logic [2:0] f_q;
   logic       w_tc, w_wrap, w_lerr;
   logic       s_tc, s_wrap, s_lerr;
   logic       f_tc, f_wrap, f_lerr;

   logic       c_en, c_up;
   logic [3:0] lo_q, hi_q;
   logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lerr, hi_lerr;

   int checks = 0;
   int errors = 0;

   // Reference model state: plain integers.
   int mq_w, mq_s, mq_f, m_cas;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up), .clr(a_clr),
      .load(a_load), .load_val(a_lv), .q(w_q), .tc(w_tc), .wrap(w_wrap),
      .load_err(w_lerr));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up), .clr(a_clr),
      .load(a_load), .load_val(a_lv), .q(s_q), .tc(s_tc), .wrap(s_wrap),
      .load_err(s_lerr));

   mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_full (
      .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up), .clr(a_clr),
      .load(a_load), .load_val(a_lv[2:0]), .q(f_q), .tc(f_tc), .wrap(f_wrap),
      .load_err(f_lerr));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
      .clk(clk), .reset(reset), .en(c_en), .up_dn(c_up), .clr(1'b0),
      .load(1'b0), .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap),
      .load_err(lo_lerr));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
      .clk(clk), .reset(reset), .en(lo_tc), .up_dn(c_up), .clr(1'b0),
      .load(1'b0), .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap),
      .load_err(hi_lerr));

   typedef struct {
      bit en;
      bit up;
      bit clr;
      bit load;
      int lv;
      int q;
      bit wrap;
      bit lerr;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One edge of a counter with range 0..m-1, straight from the rules:
   // clear, else load (clamped), else step and fold back into range.
   function automatic void ref_step(input int q, input int m, input bit sat,
                                    input bit en, input bit up, input bit clr,
                                    input bit load, input int lv,
                                    output int nq, output bit nw, output bit nl);
      int t;
      nq = q;
      nw = 1'b0;
      nl = 1'b0;
      if (clr) begin
         nq = 0;
      end else if (load) begin
         if (lv < m) nq = lv;
         else begin
            nq = m - 1;
            nl = 1'b1;
         end
      end else if (en) begin
         t = up ? q + 1 : q - 1;
         if (t < 0 || t >= m) begin
            nw = 1'b1;
            nq = sat ? q : (t + m) % m;
         end else begin
            nq = t;
         end
      end
   endfunction

   // Check tc with the current inputs, take one edge, compare everything.
   task automatic tick();
      int nw_q, ns_q, nf_q, ncas;
      bit ww, wl, sw, sl, fw, fl;
      #2;
      check("w_tc", 64'(w_tc), 64'(a_en && (a_up ? mq_w == 9 : mq_w == 0)));
      check("s_tc", 64'(s_tc), 64'(a_en && (a_up ? mq_s == 9 : mq_s == 0)));
      check("f_tc", 64'(f_tc), 64'(a_en && (a_up ? mq_f == 7 : mq_f == 0)));
      ref_step(mq_w, 10, 1'b0, a_en, a_up, a_clr, a_load, int'(a_lv), nw_q, ww, wl);
      ref_step(mq_s, 10, 1'b1, a_en, a_up, a_clr, a_load, int'(a_lv), ns_q, sw, sl);
      ref_step(mq_f, 8, 1'b0, a_en, a_up, a_clr, a_load, int'(a_lv[2:0]), nf_q, fw, fl);
      ncas = m_cas;
      if (c_en) ncas = c_up ? (m_cas + 1) % 100 : (m_cas + 99) % 100;
      @(posedge clk);
      #1;
      mq_w  = nw_q;
      mq_s  = ns_q;
      mq_f  = nf_q;
      m_cas = ncas;
      check("w_q",    64'(w_q),    64'(mq_w));
      check("w_wrap", 64'(w_wrap), 64'(ww));
      check("w_lerr", 64'(w_lerr), 64'(wl));
      check("s_q",    64'(s_q),    64'(mq_s));
      check("s_wrap", 64'(s_wrap), 64'(sw));
      check("s_lerr", 64'(s_lerr), 64'(sl));
      check("f_q",    64'(f_q),    64'(mq_f));
      check("f_wrap", 64'(f_wrap), 64'(fw));
      check("f_lerr", 64'(f_lerr), 64'(fl));
      check("cascade", 64'(int'(hi_q) * 10 + int'(lo_q)), 64'(m_cas));
   endtask

   // Assert reset between edges; outputs must clear without a clock.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_w_q",    64'(w_q),    64'd0);
      check("rst_w_wrap", 64'(w_wrap), 64'd0);
      check("rst_w_lerr", 64'(w_lerr), 64'd0);
      check("rst_s_q",    64'(s_q),    64'd0);
      check("rst_s_wrap", 64'(s_wrap), 64'd0);
      check("rst_f_q",    64'(f_q),    64'd0);
      check("rst_cas",    64'({hi_q, lo_q}), 64'd0);
      mq_w  = 0;
      mq_s  = 0;
      mq_f  = 0;
      m_cas = 0;
      #1 reset = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1,  7, 7, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 8, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 9, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 9, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12, 9, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,  0, 9, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 15, 9, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1,  3, 0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0,  0, 9, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0,  0, 9, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1,  9, 9, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 0, 1'b1, 1'b0};

      reset  = 1'b0;
      a_en   = 1'b1;
      a_up   = 1'b0;
      a_clr  = 1'b0;
      a_load = 1'b0;
      a_lv   = 4'd0;
      c_en   = 1'b0;
      c_up   = 1'b1;
      mq_w   = 0;
      mq_s   = 0;
      mq_f   = 0;
      m_cas  = 0;

      // Reset state; tc follows en & ~up_dn while held in reset.
      #3;
      check("rst0_q",     64'(w_q),    64'd0);
      check("rst0_wrap",  64'(w_wrap), 64'd0);
      check("rst0_lerr",  64'(w_lerr), 64'd0);
      check("rst0_tc_dn", 64'(w_tc),   64'd1);
      a_up = 1'b1;
      #1;
      check("rst0_tc_up", 64'(w_tc),   64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Count up from reset: 1..9, 0, 1.
      for (int i = 0; i < 11; i++) begin
         tick();
         check("up_q",    64'(w_q),    64'((i + 1) % 10));
         check("up_wrap", 64'(w_wrap), 64'(i == 9));
      end

      // Count down from reset: 9 (with wrap), 8.
      async_reset();
      a_up = 1'b0;
      tick();
      check("dn_q",    64'(w_q),    64'd9);
      check("dn_wrap", 64'(w_wrap), 64'd1);
      tick();
      check("dn_q2",   64'(w_q),    64'd8);
      check("dn_wrap2", 64'(w_wrap), 64'd0);

      // Priority / load / clear vectors.
      for (int i = 0; i < 16; i++) begin
         a_en   = vecs[i].en;
         a_up   = vecs[i].up;
         a_clr  = vecs[i].clr;
         a_load = vecs[i].load;
         a_lv   = 4'(vecs[i].lv);
         tick();
         check("vec_q",    64'(w_q),    64'(vecs[i].q));
         check("vec_wrap", 64'(w_wrap), 64'(vecs[i].wrap));
         check("vec_lerr", 64'(w_lerr), 64'(vecs[i].lerr));
      end

      // Saturation: climb to 9, hold three cycles with wrap, then step down.
      a_en   = 1'b0;
      a_load = 1'b0;
      a_clr  = 1'b1;
      tick();
      a_clr = 1'b0;
      a_en  = 1'b1;
      a_up  = 1'b1;
      repeat (9) tick();
      check("sat_top",      64'(s_q),    64'd9);
      check("sat_top_wrap", 64'(s_wrap), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_hold_q",    64'(s_q),    64'd9);
         check("sat_hold_wrap", 64'(s_wrap), 64'd1);
      end
      a_up = 1'b0;
      tick();
      check("sat_dn_q",    64'(s_q),    64'd8);
      check("sat_dn_wrap", 64'(s_wrap), 64'd0);

      // Asynchronous reset mid-count, then first edge after release.
      a_en   = 1'b0;
      a_load = 1'b1;
      a_lv   = 4'd5;
      tick();
      check("mid_q5", 64'(w_q), 64'd5);
      a_load = 1'b0;
      async_reset();
      a_en = 1'b1;
      a_up = 1'b1;
      tick();
      check("rel_q1", 64'(w_q), 64'd1);

      // A pending load_err pulse is killed by reset.
      a_en   = 1'b0;
      a_load = 1'b1;
      a_lv   = 4'd14;
      tick();
      check("lerr_pulse", 64'(w_lerr), 64'd1);
      a_load = 1'b0;
      async_reset();

      // Decimal cascade: 00..99 then 00, then one step down to 99.
      c_en = 1'b1;
      c_up = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         check("cas_up", 64'(int'(hi_q) * 10 + int'(lo_q)), 64'((i + 1) % 100));
      end
      c_up = 1'b0;
      tick();
      check("cas_dn", 64'(int'(hi_q) * 10 + int'(lo_q)), 64'd99);

      // Random interleaving against the model.
      for (int i = 0; i < 400; i++) begin
         a_en   = ($urandom_range(0, 3) != 0);
         a_up   = 1'($urandom_range(0, 1));
         a_clr  = ($urandom_range(0, 15) == 0);
         a_load = ($urandom_range(0, 7) == 0);
         a_lv   = 4'($urandom_range(0, 15));
         c_en   = ($urandom_range(0, 3) != 0);
         c_up   = 1'($urandom_range(0, 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
